tpu_tile_scheduler: RTL and testbench

Sequences the 4x4 TPU tile engine over a full matrix job of `mt x nt` output tiles with shared reduction depth K. It sits between the CFU command decoder and the TPU. For each tile it clears the engine, starts it with the right A/B buffer base addresses, and waits for completion. It then drains the four 128-bit C rows into a ready/valid result stream.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/tpu_tile_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_tpu_tile_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Constants and state encoding shared by the TPU tile scheduler and the TPU array.
package tpu_pkg;

    localparam int TILE       = 4;
    localparam int C_W        = 128;
    localparam int WD_MAX_DEF = 1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_RD,
        S_EMIT,
        S_NEXT
    } state_e;

endpackage

// File: rtl/tpu_tile_scheduler.sv
// Walks an mt x nt grid of 4x4 output tiles. For each tile it clears and starts
// the TPU, waits for completion, then streams the four C rows out.
//   state   | meaning
//   S_IDLE  | accept a job; an illegal job sets err and pulses done
//   S_CLR   | hold TPU in reset and clear the accumulators
//   S_START | one-cycle start pulse
//   S_WAIT  | wait for busy to drop; the watchdog bounds this wait
//   S_RD    | present the C row index to the buffer
//   S_EMIT  | offer the row on the result stream until it is accepted
//   S_NEXT  | advance the tile indices, or finish the job
module tpu_tile_scheduler
    import tpu_pkg::*;
#(
    parameter int K_W    = 9,
    parameter int T_W    = 5,
    parameter int BASE_W = 12,
    parameter int WD_MAX = WD_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [T_W-1:0]    cmd_mt,
    input  logic [T_W-1:0]    cmd_nt,
    input  logic [K_W-1:0]    cmd_k,
    input  logic [31:0]       cmd_offset,
    output logic              tpu_rst_n,
    output logic              tpu_rst_acc,
    output logic              tpu_in_valid,
    output logic [K_W-1:0]    tpu_K,
    output logic [7:0]        tpu_M,
    output logic [7:0]        tpu_N,
    output logic [31:0]       tpu_offset,
    input  logic              tpu_busy,
    output logic [BASE_W-1:0] a_base,
    output logic [BASE_W-1:0] b_base,
    output logic [1:0]        c_rd_index,
    input  logic [C_W-1:0]    c_rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [C_W-1:0]    res_data,
    output logic              res_last,
    output logic              done,
    output logic              err
);

    localparam int WD_W = $clog2(WD_MAX + 1);

    state_e             state_q, state_d;
    logic [T_W-1:0]     mt_q, mt_d, nt_q, nt_d, mi_q, mi_d, ni_q, ni_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [31:0]        off_q, off_d;
    logic [1:0]         row_q, row_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [BASE_W-1:0]  a_q, a_d, b_q, b_d;
    logic [C_W-1:0]     data_q, data_d;
    logic               hold_q, hold_d, err_q, err_d, done_q, done_d;
    logic               last_tile;

    assign last_tile = (mi_q == mt_q - T_W'(1)) && (ni_q == nt_q - T_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mt_q    <= '0;
            nt_q    <= '0;
            mi_q    <= '0;
            ni_q    <= '0;
            k_q     <= '0;
            off_q   <= '0;
            row_q   <= '0;
            wd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            nt_q    <= nt_d;
            mi_q    <= mi_d;
            ni_q    <= ni_d;
            k_q     <= k_d;
            off_q   <= off_d;
            row_q   <= row_d;
            wd_q    <= wd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mt_d         = mt_q;
        nt_d         = nt_q;
        mi_d         = mi_q;
        ni_d         = ni_q;
        k_d          = k_q;
        off_d        = off_q;
        row_d        = row_q;
        wd_d         = wd_q;
        a_d          = a_q;
        b_d          = b_q;
        data_d       = data_q;
        hold_d       = hold_q;
        err_d        = err_q;
        done_d       = 1'b0;
        cmd_ready    = 1'b0;
        tpu_rst_acc  = 1'b0;
        tpu_in_valid = 1'b0;
        res_valid    = 1'b0;
        res_last     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    mt_d  = cmd_mt;
                    nt_d  = cmd_nt;
                    k_d   = cmd_k;
                    off_d = cmd_offset;
                    mi_d  = '0;
                    ni_d  = '0;
                    row_d = '0;
                    if (cmd_mt == '0 || cmd_nt == '0 || cmd_k == '0) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                tpu_rst_acc = 1'b1;
                a_d         = BASE_W'(mi_q) * BASE_W'(k_q);
                b_d         = BASE_W'(ni_q) * BASE_W'(k_q);
                state_d     = S_START;
            end
            S_START: begin
                tpu_in_valid = 1'b1;
                wd_d         = WD_W'(WD_MAX - 1);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (!tpu_busy) begin
                    state_d = S_RD;
                end else if (wd_q == '0) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_RD: begin
                hold_d  = 1'b0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                res_valid = 1'b1;
                res_last  = (row_q == 2'd3) && last_tile;
                // The buffer output is only guaranteed on the first EMIT cycle; keep a copy for stalls.
                if (!hold_q) begin
                    data_d = c_rd_data;
                    hold_d = 1'b1;
                end
                if (res_ready) begin
                    row_d   = row_q + 2'd1;
                    state_d = (row_q == 2'd3) ? S_NEXT : S_RD;
                end
            end
            S_NEXT: begin
                if (last_tile) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (ni_q == nt_q - T_W'(1)) begin
                        ni_d = '0;
                        mi_d = mi_q + T_W'(1);
                    end else begin
                        ni_d = ni_q + T_W'(1);
                    end
                    state_d = S_CLR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign res_data   = (state_q == S_EMIT && !hold_q) ? c_rd_data : data_q;
    assign tpu_rst_n  = !(rst || state_q == S_CLR);
    assign c_rd_index = row_q;
    assign a_base     = a_q;
    assign b_base     = b_q;
    assign tpu_K      = k_q;
    assign tpu_M      = 8'(TILE);
    assign tpu_N      = 8'(TILE);
    assign tpu_offset = off_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Bench for tpu_tile_scheduler: a behavioural TPU/C-buffer model, a result
// monitor, and directed plus randomized jobs checked against an expected stream.
module tb_tpu_tile_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [4:0]   cmd_mt = '0;
    logic [4:0]   cmd_nt = '0;
    logic [8:0]   cmd_k = '0;
    logic [31:0]  cmd_offset = '0;
    logic         tpu_rst_n, tpu_rst_acc, tpu_in_valid;
    logic [8:0]   tpu_K;
    logic [7:0]   tpu_M, tpu_N;
    logic [31:0]  tpu_offset;
    logic         tpu_busy;
    logic [11:0]  a_base, b_base;
    logic [1:0]   c_rd_index;
    logic [127:0] c_rd_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_data;
    logic         res_last, done, err;

    tpu_tile_scheduler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mt(cmd_mt), .cmd_nt(cmd_nt),
        .cmd_k(cmd_k), .cmd_offset(cmd_offset),
        .tpu_rst_n(tpu_rst_n), .tpu_rst_acc(tpu_rst_acc), .tpu_in_valid(tpu_in_valid),
        .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N), .tpu_offset(tpu_offset),
        .tpu_busy(tpu_busy), .a_base(a_base), .b_base(b_base),
        .c_rd_index(c_rd_index), .c_rd_data(c_rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Each C row encodes the start parameters the TPU saw plus the row number (1-based).
    function automatic logic [127:0] mkrow(input logic [11:0] a, input logic [11:0] b,
                                           input logic [31:0] off, input int idx,
                                           input logic [8:0] k, input logic [1:0] r);
        return {4'h0, a, 4'h0, b, off, 16'(idx), 7'h0, k, 24'h0, 8'(r) + 8'd1};
    endfunction

    logic        busy_r = 1'b0;
    int          busy_cnt = 0;
    bit          hang = 1'b0;
    logic [11:0] cap_a = '0, cap_b = '0;
    logic [31:0] cap_off = '0;
    logic [8:0]  cap_k = '0;
    int          cap_idx = 0;
    int          starts_total = 0;
    int          clr_cnt = 0;
    int          start_cyc = 0;
    logic [23:0] base_q[$];

    assign tpu_busy = tpu_in_valid | busy_r;

    initial begin
        logic [1:0] idx;
        forever begin
            @(negedge clk);
            if (!tpu_rst_n) busy_cnt = 0;
            if (!tpu_rst_n && tpu_rst_acc) clr_cnt++;
            if (tpu_in_valid) begin
                cap_a   = a_base;
                cap_b   = b_base;
                cap_off = tpu_offset;
                cap_k   = tpu_K;
                cap_idx = starts_total;
                starts_total++;
                start_cyc = cyc;
                base_q.push_back({a_base, b_base});
                busy_cnt = hang ? 1 : int'($urandom_range(0, 6));
            end
            idx = c_rd_index;
            @(posedge clk);
            #1;
            c_rd_data = mkrow(cap_a, cap_b, cap_off, cap_idx, cap_k, idx);
            busy_r = (busy_cnt > 0);
            if (busy_cnt > 0 && !hang) busy_cnt--;
        end
    end

    int rmode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       res_ready = 1'b1;
            1:       res_ready = (cyc % 3 == 0);
            2:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
    end

    logic [127:0] got_d[$];
    logic         got_l[$];
    int           done_cnt = 0, stall_err = 0, both_cnt = 0, valid_seen = 0, done_cyc = 0;
    logic         prev_stall = 1'b0, prev_last = 1'b0;
    logic [127:0] prev_data = '0;

    initial forever begin
        @(negedge clk);
        if (!rst && prev_stall && (!res_valid || res_data !== prev_data || res_last !== prev_last))
            stall_err++;
        prev_stall = !rst && res_valid && !res_ready;
        prev_data  = res_data;
        prev_last  = res_last;
        if (res_valid) valid_seen++;
        if (res_valid && res_ready) begin
            got_d.push_back(res_data);
            got_l.push_back(res_last);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done && res_valid && res_ready) both_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done within budget"}, 128'(done_cnt > 0), 128'(1));
    endtask

    task automatic issue(input int mt, input int nt, input int k, input logic [31:0] off);
        cmd_mt     = 5'(mt);
        cmd_nt     = 5'(nt);
        cmd_k      = 9'(k);
        cmd_offset = off;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic run_job(input int mt, input int nt, input int k, input logic [31:0] off,
                           input int rm, input string tag);
        logic [127:0] exp_d[$];
        logic         exp_l[$];
        logic [23:0]  exp_b[$];
        int sb, c0;
        sb = starts_total;
        c0 = clr_cnt;
        for (int mi = 0; mi < mt; mi++)
            for (int ni = 0; ni < nt; ni++) begin
                exp_b.push_back({12'(mi * k), 12'(ni * k)});
                for (int r = 0; r < 4; r++) begin
                    exp_d.push_back(mkrow(12'(mi * k), 12'(ni * k), off, sb + mi * nt + ni, 9'(k), 2'(r)));
                    exp_l.push_back(mi == mt - 1 && ni == nt - 1 && r == 3);
                end
            end
        got_d.delete();
        got_l.delete();
        base_q.delete();
        done_cnt = 0; stall_err = 0; both_cnt = 0;
        rmode = rm;
        chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'(1));
        issue(mt, nt, k, off);
        chk({tag, " err cleared on accept"}, 128'(err), 128'(0));
        wait_done(4000, tag);
        repeat (3) @(negedge clk);
        chk({tag, " result count"}, 128'(got_d.size()), 128'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++)
            if (i < got_d.size()) begin
                chk($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
                chk($sformatf("%s last[%0d]", tag, i), 128'(got_l[i]), 128'(exp_l[i]));
            end
        chk({tag, " base count"}, 128'(base_q.size()), 128'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++)
            if (i < base_q.size())
                chk($sformatf("%s bases[%0d]", tag, i), 128'(base_q[i]), 128'(exp_b[i]));
        chk({tag, " starts"}, 128'(starts_total - sb), 128'(mt * nt));
        chk({tag, " clears"}, 128'(clr_cnt - c0), 128'(mt * nt));
        chk({tag, " done pulses"}, 128'(done_cnt), 128'(1));
        chk({tag, " err"}, 128'(err), 128'(0));
        chk({tag, " stall stability"}, 128'(stall_err), 128'(0));
        chk({tag, " done vs last handshake"}, 128'(both_cnt), 128'(0));
    endtask

    task automatic bad_cmd(input int mt, input int nt, input int k, input string tag);
        int sb;
        sb = starts_total;
        done_cnt = 0;
        issue(mt, nt, k, 32'h55);
        wait_done(10, tag);
        repeat (3) @(negedge clk);
        chk({tag, " err set"}, 128'(err), 128'(1));
        chk({tag, " no start"}, 128'(starts_total - sb), 128'(0));
        chk({tag, " done pulses"}, 128'(done_cnt), 128'(1));
        chk({tag, " back in idle"}, 128'(cmd_ready), 128'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, 128'(cmd_ready), 128'(1));
        chk({tag, " tpu_rst_acc"}, 128'(tpu_rst_acc), 128'(0));
        chk({tag, " tpu_in_valid"}, 128'(tpu_in_valid), 128'(0));
        chk({tag, " res_valid"}, 128'(res_valid), 128'(0));
        chk({tag, " res_last"}, 128'(res_last), 128'(0));
        chk({tag, " done"}, 128'(done), 128'(0));
        chk({tag, " err"}, 128'(err), 128'(0));
        chk({tag, " a_base"}, 128'(a_base), 128'(0));
        chk({tag, " b_base"}, 128'(b_base), 128'(0));
        chk({tag, " c_rd_index"}, 128'(c_rd_index), 128'(0));
        chk({tag, " res_data"}, res_data, 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst tpu_rst_n held", 128'(tpu_rst_n), 128'(0));
        chk_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst tpu_rst_n", 128'(tpu_rst_n), 128'(1));
        chk("tpu_M", 128'(tpu_M), 128'(4));
        chk("tpu_N", 128'(tpu_N), 128'(4));
        chk_reset_outputs("post-rst");

        run_job(1, 1, 8, 32'd128, 0, "j1x1");
        run_job(2, 3, 16, 32'h0, 0, "j2x3");
        run_job(1, 1, int'($urandom_range(1, 256)), $urandom, 1, "stall1in3");
        bad_cmd(1, 1, 0, "k0");
        run_job(1, 2, int'($urandom_range(1, 256)), $urandom, 0, "after_k0");
        bad_cmd(0, 2, 5, "mt0");
        bad_cmd(3, 0, 5, "nt0");
        for (int i = 0; i < 4; i++)
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 256)), $urandom, 2, $sformatf("rnd%0d", i));
        run_job(16, 2, 256, $urandom, 0, "max_base");

        // TPU never finishes: watchdog must give up after 1023 WAIT cycles
        hang = 1'b1;
        done_cnt = 0;
        valid_seen = 0;
        rmode = 0;
        issue(1, 1, 5, 32'h9);
        wait_done(1200, "hang");
        repeat (3) @(negedge clk);
        chk("hang err", 128'(err), 128'(1));
        chk("hang no results", 128'(valid_seen), 128'(0));
        chk("hang timeout cycles", 128'(done_cyc - start_cyc), 128'(1024));
        chk("hang done pulses", 128'(done_cnt), 128'(1));
        chk("hang idle", 128'(cmd_ready), 128'(1));
        hang = 1'b0;
        run_job(1, 1, 3, 32'h77, 0, "after_hang");

        // Abort a 2x2 job while tile 1 is being emitted
        done_cnt = 0;
        got_d.delete();
        got_l.delete();
        rmode = 0;
        issue(2, 2, int'($urandom_range(1, 256)), $urandom);
        n = 0;
        while (got_d.size() < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid tile0 drained", 128'(got_d.size() >= 4), 128'(1));
        rmode = 3;
        @(negedge clk);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid in emit", 128'(res_valid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid tpu_rst_n", 128'(tpu_rst_n), 128'(0));
        chk_reset_outputs("rstmid");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid no done", 128'(done_cnt), 128'(0));
        run_job(2, 2, int'($urandom_range(1, 256)), $urandom, 2, "after_rstmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
